// File: rtl/sample_strobe_capture.sv
// -----------------------------------------------------------------------------
// sample_strobe_capture
//
// Captures an externally strobed sample into a small FIFO that feeds the
// moving-average core. The asynchronous strobe is synchronised (s1, s2) and
// delayed once more (s3) for edge detection. data_in is sampled directly on the
// capture cycle; the source holds it stable across the synchroniser latency.
//
// Ports
//   clk         : system clock, all logic on the rising edge
//   rst_n       : asynchronous active-low reset
//   ena         : capture enable (draining continues while low)
//   strobe_in   : asynchronous sample strobe
//   data_in     : sample qualified by strobe_in transitions
//   edge_mode   : 0 = capture on rising strobe edges, 1 = on both edges
//   out_ready   : downstream accepts the head sample
//   out_valid   : FIFO head sample available
//   out_data    : FIFO head sample (registered storage, no path from data_in)
//   fifo_level  : number of stored samples, 0..DEPTH
//   overrun     : sticky, a capture was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module sample_strobe_capture #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       strobe_in,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       edge_mode,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Strobe synchroniser and edge-detect delay.
    logic s1, s2, s3;
    logic strobe_edge, strobe_rise, capture;

    // FIFO storage and bookkeeping.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level;
    logic              full, pop, push;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the pre-edge values of its neighbours.
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= strobe_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // can leave it unassigned and infer a latch.
        strobe_edge = 1'b0;
        strobe_rise = 1'b0;
        capture     = 1'b0;
        strobe_edge = s2 ^ s3;
        strobe_rise = s2 & ~s3;
        capture     = ena & (edge_mode ? strobe_edge : strobe_rise);
    end

    // Fullness is taken from the level count; equal pointers alone would be
    // ambiguous between empty and full.
    assign full      = (level == LW'(DEPTH));
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts a capture if the head leaves in the same cycle.
    assign push      = capture & (~full | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
            // NOTE: the storage is reset as well because out_data is read
            // straight from it and must show 0 immediately on reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (capture && full && !pop) begin
                overrun <= 1'b1;
            end
        end
    end

    assign out_data   = mem[rd_ptr];
    assign fifo_level = level;

endmodule

// File: tb/tb_sample_strobe_capture.sv
module tb_sample_strobe_capture;

    localparam int DATA_W = 10;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic              strobe_in;
    logic [DATA_W-1:0] data_in;
    logic              edge_mode;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [$clog2(DEPTH):0] fifo_level;
    logic              overrun;

    int tests_run = 0;
    int tests_failed = 0;

    sample_strobe_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .strobe_in  (strobe_in),
        .data_in    (data_in),
        .edge_mode  (edge_mode),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .fifo_level (fifo_level),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: strobe_in values sampled at each edge since reset.
    // A capture is evaluated at edge m from the samples taken at edges m-2 and
    // m-3 (two synchroniser stages plus the edge-detect delay). The FIFO is a
    // plain queue: head leaves first, then the capture joins the tail.
    bit          hist[$];
    int unsigned exp_q[$];
    bit          exp_ovr;
    int unsigned popped[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            exp_q.delete();
            exp_ovr = 1'b0;
        end else begin
            bit cur_s, prev_s, cap, pop_now;
            int n;
            if (out_valid && out_ready) popped.push_back(int'(out_data));
            hist.push_back(strobe_in);
            n = hist.size();
            cur_s  = (n >= 3) ? hist[n-3] : 1'b0;
            prev_s = (n >= 4) ? hist[n-4] : 1'b0;
            if (n > 4) hist.pop_front();
            cap = ena && (edge_mode ? (cur_s != prev_s) : (cur_s && !prev_s));
            pop_now = (exp_q.size() != 0) && out_ready;
            if (pop_now) void'(exp_q.pop_front());
            if (cap) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(int'(data_in));
                else exp_ovr = 1'b1;
            end
            #1;
            if (rst_n) begin
                check("model_valid", out_valid, exp_q.size() != 0);
                check("model_level", fifo_level, exp_q.size());
                check("model_overrun", overrun, exp_ovr);
                if (exp_q.size() != 0) check("model_data", out_data, exp_q[0]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic rise_pulse(input int unsigned d);
        data_in = DATA_W'(d);
        tick(1);
        strobe_in = 1'b1;
        tick(6);
        strobe_in = 1'b0;
        tick(6);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; strobe_in = 1'b0; data_in = '0;
        edge_mode = 1'b0; out_ready = 1'b0;
        tick(3);
        check("reset_level", fifo_level, 0);
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, 0);
        check("reset_overrun", overrun, 0);
        rst_n = 1'b1;
        tick(2);

        // Single capture with exact latency.
        data_in = 10'h2A5;
        tick(1);
        strobe_in = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("single_not_yet_valid", out_valid, 0);
        @(posedge clk); #2;
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 10'h2A5);
        check("single_level", fifo_level, 1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #2;
        check("single_drained", fifo_level, 0);
        @(negedge clk);
        strobe_in = 1'b0;
        tick(6);

        // Both edges, continuous draining.
        edge_mode = 1'b1;
        popped.delete();
        for (int i = 0; i < 6; i++) begin
            data_in = DATA_W'(i);
            tick(1);
            strobe_in = ~strobe_in;
            tick(24);
        end
        check("both_count", popped.size(), 6);
        for (int i = 0; i < 6; i++) check("both_order", (i < popped.size()) ? popped[i] : 32'hFFFF, i);
        check("both_overrun", overrun, 0);

        // Overflow: five rising strobes into a stalled FIFO.
        edge_mode = 1'b0;
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) rise_pulse(i);
        check("ovf_level", fifo_level, 4);
        check("ovf_overrun", overrun, 1);
        popped.delete();
        out_ready = 1'b1;
        tick(8);
        check("ovf_drain_count", popped.size(), 4);
        for (int i = 0; i < 4; i++) check("ovf_drain_data", (i < popped.size()) ? popped[i] : 32'hFFFF, i + 1);
        check("ovf_sticky", overrun, 1);

        // Full FIFO with a capture coinciding with a pop.
        do_reset();
        out_ready = 1'b0;
        for (int i = 10; i <= 13; i++) rise_pulse(i);
        check("fullpop_pre_level", fifo_level, 4);
        data_in = 10'd14;
        tick(1);
        strobe_in = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #2;
        check("fullpop_level", fifo_level, 4);
        check("fullpop_overrun", overrun, 0);
        @(negedge clk);
        out_ready = 1'b0;
        strobe_in = 1'b0;
        tick(6);
        popped.delete();
        out_ready = 1'b1;
        tick(8);
        check("fullpop_count", popped.size(), 4);
        for (int i = 0; i < 4; i++) check("fullpop_order", (i < popped.size()) ? popped[i] : 32'hFFFF, i + 11);

        // Enable gating.
        popped.delete();
        ena = 1'b0;
        for (int i = 0; i < 3; i++) rise_pulse(30 + i);
        strobe_in = 1'b1;
        tick(6);
        ena = 1'b1;
        tick(10);
        check("ena_no_capture", popped.size(), 0);
        check("ena_level", fifo_level, 0);
        strobe_in = 1'b0;
        tick(6);
        rise_pulse(10'h155);
        check("ena_next_edge", popped.size(), 1);
        check("ena_next_data", (popped.size() > 0) ? popped[0] : 32'hFFFF, 10'h155);

        // Asynchronous reset mid-stream, strobe high at release.
        out_ready = 1'b0;
        for (int i = 21; i <= 23; i++) rise_pulse(i);
        check("rst_pre_level", fifo_level, 3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        strobe_in = 1'b1;
        data_in = 10'h03C;
        #1;
        check("rst_async_level", fifo_level, 0);
        check("rst_async_valid", out_valid, 0);
        check("rst_async_data", out_data, 0);
        check("rst_async_overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(8);
        check("rst_release_level", fifo_level, 1);
        check("rst_release_data", out_data, 10'h03C);
        tick(10);
        check("rst_release_once", fifo_level, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sample_strobe_capture.md
SAMPLE_STROBE_CAPTURE -- requirements
Module: sample_strobe_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 10, sample width matching the moving-average core input.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port ena  input  1  capture enable; 0 suppresses new captures only.
REQ-006 SHALL have port strobe_in  input  1  asynchronous external sample strobe.
REQ-007 SHALL have port data_in  input  DATA_W  external sample, qualified by strobe_in edges.
REQ-008 SHALL have port edge_mode  input  1  0 = rising edges only, 1 = both edges.
REQ-009 SHALL have port out_ready  input  1  downstream (moving-average core) accepts the sample.
REQ-010 SHALL have port out_valid  output  1  FIFO head sample available.
REQ-011 SHALL have port out_data  output  DATA_W  FIFO head sample.
REQ-012 SHALL have port fifo_level  output  clog2(DEPTH)+1  current entry count, 0..DEPTH.
REQ-013 SHALL have port overrun  output  1  sticky flag: a capture was dropped while the FIFO was full.

Function
REQ-014 SHALL synchronise strobe_in through a 2-FF chain (s1, s2) and register s2 into s3; edge = s2 XOR s3, rise = s2 AND NOT s3.
REQ-015 SHALL raise capture when ena=1 and either (edge_mode=1 and edge=1) or (edge_mode=0 and rise=1).
REQ-016 SHALL sample data_in unsynchronised into the FIFO on the clock edge where capture=1; the source holds data_in stable from 1 cycle before to 4 cycles after each strobe transition.
REQ-017 SHALL have a fixed latency from strobe_in transition (set up before edge 0) to out_valid=1: after edge 2, with the FIFO empty.
REQ-018 SHALL pop on a rising edge when out_valid=1 and out_ready=1, with the next entry or out_valid=0 visible after that edge.
REQ-019 SHALL drive out_data from the FIFO head register (no combinational path from data_in), holding it while out_valid=1 and out_ready=0.
REQ-020 SHALL, on capture with the FIFO full and no pop that cycle, drop the sample, leave the contents unchanged and set overrun=1.
REQ-021 SHALL, on capture with the FIFO full and a pop in the same cycle, accept the sample, keep fifo_level=DEPTH and leave overrun unchanged.
REQ-022 SHALL, on capture and pop in the same cycle at any level, keep fifo_level unchanged and preserve order.
REQ-023 SHALL wrap read and write pointers modulo DEPTH; full/empty SHALL derive from fifo_level, never from pointer equality alone.
REQ-024 SHALL keep overrun at 1 until reset; no other clear.
REQ-025 SHALL, when ena=0, keep the sync chain and s3 running, keep pop/drain working, and produce no capture on the ena 0->1 transition itself.
REQ-026 SHALL make an edge_mode change take effect from the next cycle's capture evaluation, with no retroactive captures.

Reset
REQ-027 SHALL, on rst_n=0, immediately clear s1, s2, s3, pointers, fifo_level, out_valid, overrun and out_data to 0, regardless of clock.
REQ-028 SHALL discard any in-flight edge at reset release; a strobe_in already high at release SHALL produce exactly one rising capture about 2-3 cycles later, since s3 starts at 0.
REQ-029 SHALL, when reset is asserted mid-stream, flush all FIFO contents with no partial output.

Verification
REQ-030 Single capture: edge_mode=0, ena=1, data_in=0x2A5, strobe_in 0->1 before edge 0 -> out_valid=1 and out_data=0x2A5 after edge 2, fifo_level=1; out_ready=1 -> fifo_level=0.
REQ-031 Both edges: edge_mode=1, strobe_in toggling every 25 cycles, data_in incrementing 0,1,2,...; out_ready=1 -> one sample per toggle, in order, overrun=0.
REQ-032 Overflow: out_ready=0, 5 rising strobes with data 1..5 -> fifo_level=4, overrun=1; drain yields 1,2,3,4 only.
REQ-033 Full with simultaneous pop: fifo_level=4, capture coincident with out_ready=1 -> fifo_level stays 4, overrun stays 0, new sample last in order.
REQ-034 Enable gating: ena=0 across 3 strobes, then ena=1 with strobe_in steady -> no captures; the next strobe edge captures normally.
REQ-035 Async reset mid-stream: fifo_level=3, rst_n pulsed low between clock edges -> outputs 0 immediately; after release strobe_in held high -> exactly one capture.
